matmul_seq: RTL
===============

# matmul_seq

Parametrised, sequential N×N unsigned matrix multiplier, the successor of the fixed 2×2 single-cycle multiplier.
- Accepts two flattened row-major matrices over a valid/ready handshake.
- Computes C = A·B with one multiply-accumulate per clock.
- Presents the packed result over a second valid/ready handshake.
- Sits between a memory-fed operand loader and the result writeback path. It trades N³ cycles of latency for a single multiplier, instead of N³ parallel multipliers.

## Interface
- N, default 2: matrix dimension; N ≥ 2.
- DW, default 8: operand element width, unsigned.
- OW, default 8: result element width.
- Derived, not overridable: AW = 2*DW + $clog2(N), the accumulator width; IW = $clog2(N), the index width.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand pair A/B presented.
- in_ready, output, 1: block can accept operands.
- A, input, N*N*DW: matrix A, row-major, element [0][0] in the MSBs.
- B, input, N*N*DW: matrix B, same packing as A.
- out_valid, output, 1: y holds a completed result.
- out_ready, input, 1: downstream accepts y.
- y, output, N*N*OW: result C, same packing as A (element [0][0] in the MSBs).
- busy, output, 1: high in CALC or DONE.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch A and B into internal registers, clear acc, set i = j = k = 0, go to CALC.
- CALC (one MAC per cycle):
  - Each cycle computes acc ← acc + A[i][k]*B[k][j], full AW-bit precision, no intermediate overflow.
  - When k = N−1: write the final sum (acc + product) into work register C[i][j] after the width rule, clear acc, reset k to 0, and advance j, then i (row-major order).
  - Otherwise: k increments.
  - When i = j = k = N−1: copy the work register into the y register and go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready: go to IDLE.
- Width rule: the final AW-bit sum is reduced to OW bits by truncation (low OW bits kept), unless the saturation option is compiled in (see Configuration).
- y changes only on the CALC→DONE transition. It holds the previous result through IDLE and CALC.
- Operands are captured once, so A and B inputs may change freely after acceptance.
- Only one job is in flight. in_ready = 0 in CALC and DONE, so no job is accepted while busy.

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0, y = 0, state IDLE, acc = 0, i/j/k = 0.
- Latency: out_valid rises N³ rising edges after the accepting edge (N = 2 gives 8 cycles).
- Throughput with out_ready held high:
  - One job per N³ + 2 cycles.
  - The DONE→IDLE edge takes one cycle and the IDLE accept edge takes one cycle. There is no IDLE bypass.
- Backpressure: while out_valid && !out_ready, y, out_valid and the state are frozen indefinitely.
- in_valid while busy is ignored. The operand source must hold in_valid until it sees in_ready.
- Reset mid-operation (any state): asynchronous return to reset values; the in-flight job is discarded with no output.
- All outputs are registered, decoded from state or taken from the y register. There is no combinational path from any input to any output.

## Configuration
- MATMUL_SAT_EN defined: each final sum greater than 2^OW − 1 is clamped to 2^OW − 1.
- MATMUL_SAT_EN undefined: each final sum is truncated modulo 2^OW.
- Accumulation is exact in both modes; only the final reduction differs.

## Structure
- Package matmul_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - a function computing AW from DW and N;
  - the element-unpack helper mapping (row, column) to its bit offset in the packed bus.
- Sub-module matmul_mac is combinational: product, accumulate, and final reduction (truncate or saturate under MATMUL_SAT_EN).
- Top level matmul_seq holds:
  - the FSM;
  - the i/j/k counters;
  - the operand, work and y registers.

## Test plan
- Basic (N = 2, DW = OW = 8): A = 0x01020304, B = 0x05060708 → y = 0x13162B32, with out_valid exactly 8 cycles after accept.
- Overflow: A = B = 0xFFFFFFFF → without MATMUL_SAT_EN, y = 0x02020202; with MATMUL_SAT_EN, y = 0xFFFFFFFF.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE.
  - y, out_valid = 1 and in_ready = 0 stay stable.
  - A new in_valid pulse during that time is ignored.
- Reset mid-CALC: assert rst_n = 0 at cycle 3 of CALC → all outputs return to their reset values immediately and no out_valid follows. The next job yields the correct result.
- Parametric (N = 3, DW = 8, OW = 20): A = identity, B = elements 1..9 → y equals B. out_valid rises after 27 cycles.
- Back-to-back jobs with out_ready tied high: the two results are correct and in order, and accepts are spaced N³ + 2 cycles apart.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential N x N matrix multiplier.
// Build option MATMUL_SAT_EN (see matmul_mac) selects saturating result reduction.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Accumulator width: a sum of n products of two dw-bit values never overflows.
    function automatic int calc_aw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Bit offset of element (row, col) in a row-major bus with element [0][0] in the MSBs.
    function automatic int elem_off(input int row, input int col, input int n, input int w);
        return (n * n - 1 - (row * n + col)) * w;
    endfunction

endpackage

// File: rtl/matmul_if.sv
// Operand and result handshakes of matmul_seq; master drives operands, slave is the multiplier.
// Build option MATMUL_SAT_EN does not affect this interface.
interface matmul_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int OW = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*N*DW-1:0]     A;
    logic [N*N*DW-1:0]     B;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*N*OW-1:0]     y;
    logic                  busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate with final reduction to OW bits.
// MATMUL_SAT_EN defined: clamp sums above 2^OW-1; undefined: keep the low OW bits.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int OW = 8,
    localparam int AW = calc_aw(DW, N)
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [AW-1:0] i_acc,
    output logic [AW-1:0] o_sum,
    output logic [OW-1:0] o_res
);
    logic [2*DW-1:0] w_prod;

    assign w_prod = i_a * i_b;
    assign o_sum  = i_acc + AW'(w_prod);

    generate
        if (OW >= AW) begin : g_wide
            assign o_res = OW'(o_sum);
        end else begin : g_narrow
`ifdef MATMUL_SAT_EN
            assign o_res = (|o_sum[AW-1:OW]) ? {OW{1'b1}} : o_sum[OW-1:0];
`else
            assign o_res = o_sum[OW-1:0];
`endif
        end
    endgenerate
endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N unsigned matrix multiplier, one MAC per clock, row-major result order.
// Build option MATMUL_SAT_EN: saturate each result element instead of truncating it.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int OW = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    matmul_if.slave  bus
);
    localparam int AW = calc_aw(DW, N);
    localparam int IW = $clog2(N);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [1:0]          r_state;
    logic [N*N*DW-1:0]   r_a;
    logic [N*N*DW-1:0]   r_b;
    logic [AW-1:0]       r_acc;
    logic [IW-1:0]       r_i;
    logic [IW-1:0]       r_j;
    logic [IW-1:0]       r_k;
    logic [OW-1:0]       r_c [N][N];
    logic [N*N*OW-1:0]   r_y;

    logic [DW-1:0]       w_a_el [N][N];
    logic [DW-1:0]       w_b_el [N][N];
    logic [N*N*OW-1:0]   w_c_final;
    logic [AW-1:0]       w_sum;
    logic [OW-1:0]       w_res;
    logic                w_last_i;
    logic                w_last_j;
    logic                w_last_k;

    // Unpack operands; the final element bypasses r_c so y is complete on the CALC->DONE edge.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                assign w_a_el[gi][gj] = r_a[elem_off(gi, gj, N, DW) +: DW];
                assign w_b_el[gi][gj] = r_b[elem_off(gi, gj, N, DW) +: DW];
                if ((gi == N - 1) && (gj == N - 1)) begin : g_last
                    assign w_c_final[elem_off(gi, gj, N, OW) +: OW] = w_res;
                end else begin : g_keep
                    assign w_c_final[elem_off(gi, gj, N, OW) +: OW] = r_c[gi][gj];
                end
            end
        end
    endgenerate

    matmul_mac #(
        .N  (N),
        .DW (DW),
        .OW (OW)
    ) u_mac (
        .i_a   (w_a_el[r_i][r_k]),
        .i_b   (w_b_el[r_k][r_j]),
        .i_acc (r_acc),
        .o_sum (w_sum),
        .o_res (w_res)
    );

    assign w_last_i = (r_i == LAST);
    assign w_last_j = (r_j == LAST);
    assign w_last_k = (r_k == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_y     <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_c[r][c] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_last_k) begin
                        r_c[r_i][r_j] <= w_res;
                        r_acc         <= '0;
                        r_k           <= '0;
                        if (w_last_j) begin
                            r_j <= '0;
                            if (w_last_i) begin
                                r_i     <= '0;
                                r_y     <= w_c_final;
                                r_state <= S_DONE;
                            end else begin
                                r_i <= r_i + IW'(1);
                            end
                        end else begin
                            r_j <= r_j + IW'(1);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + IW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.y         = r_y;
endmodule
